// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock; start/done handshake.
// Ports: clk, rst (sync, active-high), start, dividend, divisor -> busy, done,
//   quotient, remainder, div_zero. Define DIV_SIGNED_EN for two's-complement operands.
module seq_divider #(
  parameter int WIDTH = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] quotient,
  output logic [OUT_W-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] a, a_n, qr, qr_n, m;
  logic [WIDTH-1:0] op_q, op_m;
  logic [WIDTH:0]   sh, t;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic [OUT_W-1:0] dz_rem;

`ifdef DIV_SIGNED_EN
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] fq, fr;

  assign op_q   = dividend[WIDTH-1] ? -dividend : dividend;
  assign op_m   = divisor[WIDTH-1] ? -divisor : divisor;
  assign fq     = neg_q ? -qr : qr;
  assign fr     = neg_r ? -a : a;
  assign dz_rem = OUT_W'($signed(dividend));
`else
  assign op_q   = dividend;
  assign op_m   = divisor;
  assign dz_rem = OUT_W'(dividend);
`endif

  assign busy   = (state == RUN)
`ifdef DIV_SIGNED_EN
                | (state == FIX)
`endif
                ;
  assign done   = (state == DONE);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start & ((state == IDLE) | (state == DONE));

  // One restoring step: shift {A,Qr}, trial-subtract M, keep on no borrow.
  always_comb begin
    sh = {a, qr[WIDTH-1]};
    t  = sh - {1'b0, m};
    if (!t[WIDTH]) begin
      a_n  = t[WIDTH-1:0];
      qr_n = {qr[WIDTH-2:0], 1'b1};
    end else begin
      a_n  = sh[WIDTH-1:0];
      qr_n = {qr[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          state_n = (divisor == '0) ? DONE : RUN;
        else
          state_n = IDLE;
      end
      RUN: begin
        if (last)
`ifdef DIV_SIGNED_EN
          state_n = FIX;
`else
          state_n = DONE;
`endif
      end
`ifdef DIV_SIGNED_EN
      FIX:     state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      qr        <= '0;
      m         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= '0;
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dz_rem;
          div_zero  <= 1'b1;
        end else begin
          a  <= '0;
          qr <= op_q;
          m  <= op_m;
`ifdef DIV_SIGNED_EN
          neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r <= dividend[WIDTH-1];
`endif
        end
      end else if (state == RUN) begin
        a   <= a_n;
        qr  <= qr_n;
        cnt <= cnt + 1'b1;
`ifndef DIV_SIGNED_EN
        if (last) begin
          quotient  <= OUT_W'(qr_n);
          remainder <= OUT_W'(a_n);
          div_zero  <= 1'b0;
        end
`endif
      end
`ifdef DIV_SIGNED_EN
      else if (state == FIX) begin
        quotient  <= OUT_W'($signed(fq));
        remainder <= OUT_W'($signed(fr));
        div_zero  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: queued expectations from an arithmetic model,
// checked by a monitor whenever done pulses.
module tb_seq_divider;
  localparam int W  = 4;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy, done, div_zero;
  logic [OW-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int q;
    int r;
    int dz;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  task automatic chk(string n, int act, int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", n, act, want, cyc);
    end
  endtask

  // Expected result from plain integer arithmetic.
  function automatic exp_t model(int x, int y, int now);
    exp_t r;
    r.x = x;
    r.y = y;
    if (y == 0) begin
      r.q  = 8'hFF;
      r.r  = x;
      r.dz = 1;
      r.at = now + 1;
    end else begin
      r.q  = x / y;
      r.r  = x % y;
      r.dz = 0;
      r.at = now + 1 + W;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", int'(done), 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", int'(quotient), e.q);
        chk("remainder", int'(remainder), e.r);
        chk("div_zero", int'(div_zero), e.dz);
        chk("done_cycle", cyc, e.at);
        if (e.dz == 0) begin
          chk("invariant", int'(quotient) * e.y + int'(remainder), e.x);
          chk("rem_lt_div", int'(int'(remainder) < e.y), 1);
        end
      end
    end
  end

  // Called #1 after a rising edge; start is sampled on the next edge.
  task automatic issue(int x, int y, bit push, output int at);
    exp_t r;
    dividend = W'(x);
    divisor  = W'(y);
    start    = 1'b1;
    r = model(x, y, cyc);
    at = r.at;
    if (push) sb.push_back(r);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(string n);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_done"}, int'(done), 0);
    chk({n, "_q"}, int'(quotient), 0);
    chk({n, "_r"}, int'(remainder), 0);
    chk({n, "_dz"}, int'(div_zero), 0);
  endtask

  initial begin
    int at;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(13, 3, 1, at);
    drain();
    issue(7, 0, 1, at);
    drain();
    issue(15, 1, 1, at);
    drain();
    issue(3, 7, 1, at);
    drain();

    issue(13, 3, 1, at);
    @(posedge clk);
    #1;
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    chk("busy_run", int'(busy), 1);
    @(posedge clk);
    #1 start = 1'b0;
    drain();

    issue(12, 5, 1, at);
    wait_to(at);
    chk("b2b_done", int'(done), 1);
    issue(11, 2, 1, at);
    drain();

    issue(14, 3, 0, at);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("abort");
    rst = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    chk("abort_idle", int'(busy), 0);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        issue(x, y, 1, at);
        wait_to(at);
      end
    end
    drain();

    for (int i = 0; i < 200; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1, at);
      wait_to(at + int'($urandom_range(0, 3)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
